phase_error_link_tx: RTL and testbench

Serial transmitter that carries a node's signed phase-detector error (left/above outputs of a network ADPLL node) across an inter-FPGA link to the neighbouring node, whose matching receiver reconstructs the right/bottom error inputs. A strobe from the node's divided-down generated clock captures the current error word. The block frames each word as start, LSB-first data, even parity and stop bits, and shifts it out at a fixed fpga_clk_i bit rate. A one-deep pending buffer holds at most one word waiting behind the frame in flight; newer words overwrite it.

---
 rtl/phase_error_link_tx.sv | 160 ++++++++++++++++
 tb/tb_phase_error_link_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_error_link_tx.sv
// Serial link transmitter for a node's phase-detector error word.
// Frames each captured word as start, LSB-first data, even parity, stop.
module phase_error_link_tx #(
  parameter int PDET_WIDTH     = 8,
  parameter int CLKS_PER_BIT   = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      fpga_clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      sample_i,
  input  logic [PDET_WIDTH-1:0]     error_i,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic                      pending_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (PDET_WIDTH > 1) ? $clog2(PDET_WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PDET_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state;
  logic [2:0]              sync_q;
  logic                    rise_q;
  logic [PDET_WIDTH-1:0]   pend_q;
  logic [PDET_WIDTH-1:0]   shift_q;
  logic                    par_q;
  logic [CW-1:0]           cyc_q;
  logic [BW-1:0]           bit_q;
  logic                    bit_end;
  logic                    cap;
  logic                    load;

  assign bit_end = (cyc_q == CYC_LAST);
  assign cap     = rise_q & enable_i;
  assign load    = pending_o & enable_i &
                   ((state == S_IDLE) |
                    ((state == S_STOP) & bit_end));

  // sync_q[1] is the synchronised strobe, sync_q[2] its previous value
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], sample_i};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      pend_q     <= '0;
      pending_o  <= 1'b0;
      drop_cnt_o <= '0;
    end else if (cap) begin
      pend_q    <= error_i;
      pending_o <= 1'b1;
      if (pending_o && !load && (drop_cnt_o != '1))
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end else if (load) begin
      pending_o <= 1'b0;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      state   <= S_IDLE;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cyc_q <= '0;
          if (load) begin
            state   <= S_START;
            shift_q <= pend_q;
            par_q   <= ^pend_q;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            state   <= S_DATA;
            tx_o    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              state <= S_PARITY;
              tx_o  <= par_q;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_o    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cyc_q <= '0;
            state <= S_STOP;
            tx_o  <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cyc_q <= '0;
            // chain straight into the next start bit, no idle gap
            if (load) begin
              state   <= S_START;
              shift_q <= pend_q;
              par_q   <= ^pend_q;
              tx_o    <= 1'b0;
            end else begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          cyc_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_error_link_tx.sv
// Bench for phase_error_link_tx: frame tables, corner sequences and
// randomized strobes checked cycle by cycle against a behavioural model.
module tb_phase_error_link_tx;

  localparam int W       = 8;
  localparam int CPB     = 16;
  localparam int FRAME   = (W + 3) * CPB;
  localparam int TRACE_N = 65536;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       smp = 1'b0;
  logic [7:0] err = 8'h00;

  logic       tx, busy, pend;
  logic [7:0] drop;
  logic       tx2, busy2, pend2;
  logic [1:0] drop2;

  always #5 clk = ~clk;

  phase_error_link_tx #(
    .PDET_WIDTH(W), .CLKS_PER_BIT(CPB), .DROP_CNT_WIDTH(8)
  ) dut (
    .fpga_clk_i(clk), .reset_i(rst_n), .enable_i(en),
    .sample_i(smp), .error_i(err), .tx_o(tx), .busy_o(busy),
    .pending_o(pend), .drop_cnt_o(drop)
  );

  phase_error_link_tx #(
    .PDET_WIDTH(W), .CLKS_PER_BIT(CPB), .DROP_CNT_WIDTH(2)
  ) dut_sat (
    .fpga_clk_i(clk), .reset_i(rst_n), .enable_i(en),
    .sample_i(smp), .error_i(err), .tx_o(tx2), .busy_o(busy2),
    .pending_o(pend2), .drop_cnt_o(drop2)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   ecount = 0;
  logic trace  [TRACE_N];
  logic btrace [TRACE_N];

  // model: frame start edge, pending slot, drop count, capture delay line
  int         m_load = -1;
  logic [7:0] m_frame = 8'h00;
  logic       m_pv = 1'b0;
  logic [7:0] m_pw = 8'h00;
  int         m_drops = 0;
  logic       m_prev = 1'b0;
  logic [2:0] m_pipe = 3'b000;
  logic       e_tx, e_busy;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d want %0d",
               nm, ecount, act, exp);
    end
  endtask

  task automatic model_edge();
    int   e;
    int   idx;
    logic rise, cap, idle;
    e = ecount + 1;
    if (!rst_n) begin
      m_pv = 1'b0; m_drops = 0; m_pipe = 3'b000;
      m_prev = 1'b0; m_load = -1;
    end else begin
      rise   = smp && !m_prev;
      m_prev = smp;
      cap    = m_pipe[2];
      m_pipe = {m_pipe[1:0], rise};
      idle   = (m_load < 0) || (e >= m_load + FRAME);
      if (idle && m_pv && en) begin
        m_load = e; m_frame = m_pw; m_pv = 1'b0;
      end
      if (cap && en) begin
        if (m_pv && m_drops < 255) m_drops++;
        m_pv = 1'b1;
        m_pw = err;
      end
    end
    e_busy = (m_load >= 0) && (e < m_load + FRAME);
    e_tx = 1'b1;
    if (e_busy) begin
      idx = (e - m_load) / CPB;
      if (idx == 0) e_tx = 1'b0;
      else if (idx <= W) e_tx = m_frame[idx-1];
      else if (idx == W + 1) e_tx = ^m_frame;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    ecount++;
    if (ecount < TRACE_N) begin
      trace[ecount]  = tx;
      btrace[ecount] = busy;
    end
    chk("tx", tx, e_tx);
    chk("busy", busy, e_busy);
    chk("pending", pend, m_pv);
    chk("drop_cnt", drop, m_drops);
    chk("tx_w2", tx2, e_tx);
    chk("busy_w2", busy2, e_busy);
    chk("pending_w2", pend2, m_pv);
    chk("drop_cnt_w2", drop2, (m_drops > 3) ? 3 : m_drops);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input logic [7:0] w, input int hi, output int k);
    err = w;
    smp = 1'b1;
    k = ecount + 1;
    steps(hi);
    smp = 1'b0;
  endtask

  function automatic logic [10:0] frame_at(input int s);
    logic [10:0] f;
    int ix;
    f = '1;
    for (int i = 0; i < 11; i++) begin
      ix = s + i * CPB + CPB / 2;
      if (ix >= 0 && ix < TRACE_N) f[i] = trace[ix];
    end
    return f;
  endfunction

  function automatic int busy_sum(input int a, input int b);
    int s;
    s = 0;
    for (int i = a; i <= b; i++)
      if (i >= 0 && i < TRACE_N && btrace[i]) s++;
    return s;
  endfunction

  typedef struct {
    logic [7:0]  w;
    logic [10:0] bits;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int k, k1, k2, k3, kb, kq, d0, hi, gap;
    logic [7:0] w;

    tbl[0] = '{8'h5A, 11'b1_0_01011010_0};
    tbl[1] = '{8'hFD, 11'b1_1_11111101_0};
    tbl[2] = '{8'h00, 11'b1_0_00000000_0};
    tbl[3] = '{8'hFF, 11'b1_0_11111111_0};
    tbl[4] = '{8'h80, 11'b1_1_10000000_0};
    tbl[5] = '{8'h01, 11'b1_1_00000001_0};

    rst_n = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp = ~smp;
      step();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pending", pend, 0);
      chk("rst_drop", drop, 0);
    end
    smp = 1'b0;
    rst_n = 1'b1;
    steps(4);

    for (int i = 0; i < 6; i++) begin
      strobe(tbl[i].w, 2, k);
      steps(FRAME + 20);
      chk("lat_idle", trace[k+3], 1);
      chk("lat_start", trace[k+4], 0);
      chk("frame_bits", frame_at(k + 4), tbl[i].bits);
      chk("busy_len", busy_sum(k, k + FRAME + 20), FRAME);
    end

    d0 = drop;
    strobe(8'h01, 2, k1); steps(18);
    strobe(8'h02, 2, k2); steps(18);
    strobe(8'h03, 2, k3); steps(2 * FRAME + 30);
    chk("ovr_drop", drop, d0 + 1);
    chk("ovr_first", frame_at(k1 + 4), 11'b1_1_00000001_0);
    chk("ovr_gap", trace[k1+4+FRAME], 0);
    chk("ovr_second", frame_at(k1 + 4 + FRAME), 11'b1_0_00000011_0);
    chk("ovr_idle", busy, 0);

    d0 = drop;
    strobe(8'h10, 2, k);
    for (int j = 0; j < 6; j++) begin
      steps(6);
      strobe(8'h11 + 8'(j), 2, k1);
    end
    steps(4);
    chk("sat_drop8", drop, d0 + 5);
    chk("sat_drop2", drop2, 3);
    kb = k + 4 + FRAME;
    steps(180);
    strobe(8'h77, 2, k1);
    steps(10);
    en = 1'b0;
    steps(FRAME);
    strobe(8'h99, 2, k2);
    steps(20);
    chk("dis_pending", pend, 1);
    chk("dis_tx", tx, 1);
    chk("dis_busy", busy, 0);
    chk("dis_drop", drop, d0 + 5);
    chk("dis_frame", frame_at(kb), 11'b1_1_00010110_0);
    en = 1'b1;
    kq = ecount + 1;
    steps(FRAME + 10);
    chk("en_frame", frame_at(kq), 11'b1_0_01110111_0);
    chk("en_pending", pend, 0);

    strobe(8'hC3, 2, k);
    steps(k + 4 + 4 * CPB + 6 - ecount);
    rst_n = 1'b0;
    step();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    steps(5);
    chk("mid_rst_pending", pend, 0);
    strobe(8'h3C, 2, k);
    steps(FRAME + 10);
    chk("post_rst_start", trace[k+4], 0);
    chk("post_rst_frame", frame_at(k + 4), 11'b1_0_00111100_0);

    for (int i = 0; i < 40; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      w   = 8'($urandom);
      hi  = $urandom_range(1, 5);
      gap = $urandom_range(10, 300);
      strobe(w, hi, k);
      steps(gap);
    end
    en = 1'b1;
    steps(2 * FRAME + 10);
    chk("rand_drained", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
